// File: rtl/conv_win_sched.sv
// Window scheduler for the KxK convolution core: raster-walks every output
// window, handshakes with the loader, fires the core and writes results back.
module conv_win_sched #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int K       = 7,
  parameter int CW      = 8,
  parameter int AW      = 16,
  parameter int MAX_INF = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  output logic          win_req_o,
  output logic [CW-1:0] win_x_o,
  output logic [CW-1:0] win_y_o,
  input  logic          win_ack_i,
  output logic          conv_en_o,
  input  logic          conv_valid_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int TOTAL = OUT_W * OUT_H;
  localparam int IW    = $clog2(MAX_INF + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_FIRE  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [IW-1:0] infl_q, infl_d;
  logic [AW-1:0] res_q, res_d;
  logic          win_req_q, win_req_d;
  logic          conv_en_q, conv_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          wr_fire;
  logic          last_x;
  logic          last_win;

  // A result is only accepted when the core owes us one.
  assign wr_fire  = conv_valid_i && (infl_q != '0);
  assign last_x   = (x_q == CW'(OUT_W - 1));
  assign last_win = last_x && (y_q == CW'(OUT_H - 1));

  // Next-state, window walk, in-flight tracking and registered-output decode.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = err_q;
    res_d   = wr_fire ? (res_q + AW'(1)) : res_q;
    infl_d  = infl_q;

    case ({conv_en_q, wr_fire})
      2'b10:   infl_d = infl_q + IW'(1);
      2'b01:   infl_d = infl_q - IW'(1);
      default: infl_d = infl_q;
    endcase

    if (conv_valid_i && (infl_q == '0)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_REQ;
          x_d     = '0;
          y_d     = '0;
          res_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (win_ack_i && (infl_q < IW'(MAX_INF))) begin
          state_d = S_FIRE;
        end else begin
          state_d = S_REQ;
        end
      end
      S_FIRE: begin
        // The last window leaves x/y parked on itself rather than off the map.
        if (last_win) begin
          state_d = S_DRAIN;
        end else if (last_x) begin
          state_d = S_REQ;
          x_d     = '0;
          y_d     = y_q + CW'(1);
        end else begin
          state_d = S_REQ;
          x_d     = x_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if ((infl_q == '0) && (res_q == AW'(TOTAL))) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    win_req_d = (state_d == S_REQ);
    conv_en_d = (state_d == S_FIRE);
    busy_d    = (state_d == S_REQ) || (state_d == S_FIRE) || (state_d == S_DRAIN);
    done_d    = (state_d == S_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      infl_q    <= '0;
      res_q     <= '0;
      win_req_q <= 1'b0;
      conv_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      infl_q    <= infl_d;
      res_q     <= res_d;
      win_req_q <= win_req_d;
      conv_en_q <= conv_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign win_req_o = win_req_q;
  assign win_x_o   = x_q;
  assign win_y_o   = y_q;
  assign conv_en_o = conv_en_q;
  assign wr_en_o   = wr_fire;
  assign wr_addr_o = res_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_conv_win_sched.sv
// Scoreboard bench for conv_win_sched: three instances (9x9, 9x9 with
// MAX_INF=2, 28x28), each driven by an ack-immediately loader and a 7-cycle core.
module tb_conv_win_sched;

  logic        clk = 1'b0;
  logic        rst_n      [3];
  logic        start      [3];
  logic        win_req    [3];
  logic        win_ack    [3];
  logic        conv_en    [3];
  logic        conv_valid [3];
  logic        wr_en      [3];
  logic        busy       [3];
  logic        done       [3];
  logic        err        [3];
  logic        inj        [3];
  logic [7:0]  win_x      [3];
  logic [7:0]  win_y      [3];
  logic [15:0] wr_addr    [3];

  logic [31:0] exp_win  [3][$];
  logic [31:0] exp_addr [3][$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int en_cnt [3], done_cnt [3], infl [3], peak [3], last_en_cyc [3];
  int first_wr_cyc [3], en3_cyc [3], frame_en [3], req_run [3], req_max [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [6:0] pipe_l = 7'd0;

    conv_win_sched #(
      .IMG_W  (g == 2 ? 28 : 9),
      .IMG_H  (g == 2 ? 28 : 9),
      .K      (7),
      .CW     (8),
      .AW     (16),
      .MAX_INF(g == 1 ? 2 : 8)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n[g]),
      .start_i     (start[g]),
      .win_req_o   (win_req[g]),
      .win_x_o     (win_x[g]),
      .win_y_o     (win_y[g]),
      .win_ack_i   (win_ack[g]),
      .conv_en_o   (conv_en[g]),
      .conv_valid_i(conv_valid[g]),
      .wr_en_o     (wr_en[g]),
      .wr_addr_o   (wr_addr[g]),
      .busy_o      (busy[g]),
      .done_o      (done[g]),
      .err_o       (err[g])
    );

    // Core model: fixed 7-cycle latency, not cleared by the scheduler's reset.
    always @(posedge clk) pipe_l <= {pipe_l[5:0], conv_en[g]};
    assign conv_valid[g] = pipe_l[6] | inj[g];
    assign win_ack[g]    = win_req[g];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops expected windows/addresses whenever the DUT presents them.
  initial begin
    logic [31:0] e;
    for (int i = 0; i < 3; i++) begin
      en_cnt[i] = 0; done_cnt[i] = 0; infl[i] = 0; peak[i] = 0; last_en_cyc[i] = 0;
      first_wr_cyc[i] = -1; en3_cyc[i] = 0; frame_en[i] = 0; req_run[i] = 0; req_max[i] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (!rst_n[i]) begin
          infl[i] = 0;
        end else begin
          if (start[i] && !busy[i]) begin
            frame_en[i] = 0;
            first_wr_cyc[i] = -1;
          end
          if (conv_en[i]) begin
            en_cnt[i]++;
            frame_en[i]++;
            if (exp_win[i].size() == 0) chk("unexpected_conv_en", 64'd1, 64'd0);
            else begin
              e = exp_win[i].pop_front();
              chk("window_xy", {48'd0, win_x[i], win_y[i]}, {32'd0, e});
            end
            if (i == 0 && frame_en[i] > 1) chk("en_spacing", 64'(cyc - last_en_cyc[i]), 64'd2);
            if (frame_en[i] == 3) en3_cyc[i] = cyc;
            last_en_cyc[i] = cyc;
            infl[i]++;
          end
          if (wr_en[i]) begin
            if (exp_addr[i].size() == 0) chk("unexpected_wr_en", 64'd1, 64'd0);
            else begin
              e = exp_addr[i].pop_front();
              chk("wr_addr", {48'd0, wr_addr[i]}, {32'd0, e});
            end
            if (first_wr_cyc[i] < 0) first_wr_cyc[i] = cyc;
            infl[i]--;
          end
          if (infl[i] > peak[i]) peak[i] = infl[i];
          if (win_req[i]) req_run[i]++;
          else req_run[i] = 0;
          if (req_run[i] > req_max[i]) req_max[i] = req_run[i];
          if (done[i]) begin
            done_cnt[i]++;
            chk("done_latency", 64'(cyc - last_en_cyc[i]), 64'd9);
          end
        end
      end
    end
  end

  task automatic push_frame(input int i, input int ow, input int oh);
    for (int y = 0; y < oh; y++)
      for (int x = 0; x < ow; x++)
        exp_win[i].push_back({16'd0, 8'(x), 8'(y)});
    for (int a = 0; a < ow * oh; a++) exp_addr[i].push_back(32'(a));
  endtask

  task automatic pulse_start(input int i);
    @(posedge clk); #1 start[i] = 1'b1;
    @(posedge clk); #1 start[i] = 1'b0;
  endtask

  task automatic run_frame(input int i, input int budget, input int restart, input int n_win);
    int d0;
    int e0;
    d0 = done_cnt[i];
    e0 = en_cnt[i];
    pulse_start(i);
    if (restart > 0) begin
      repeat (restart) @(posedge clk);
      #1 start[i] = 1'b1;
      @(posedge clk); #1 start[i] = 1'b0;
    end
    for (int c = 0; c < budget && done_cnt[i] == d0; c++) @(posedge clk);
    chk("done_seen", 64'(done_cnt[i] - d0), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("done_once", 64'(done_cnt[i] - d0), 64'd1);
    chk("en_per_frame", 64'(en_cnt[i] - e0), 64'(n_win));
    chk("win_queue_empty", 64'(exp_win[i].size()), 64'd0);
    chk("addr_queue_empty", 64'(exp_addr[i].size()), 64'd0);
    chk("busy_after_done", {63'd0, busy[i]}, 64'd0);
  endtask

  // Directed stimulus.
  initial begin
    int e0;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; start[i] = 1'b0; inj[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      chk("reset_outputs", {26'd0, win_req[i], conv_en[i], wr_en[i], busy[i], done[i], err[i],
                            win_x[i], win_y[i], wr_addr[i]}, 64'd0);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    // 9x9 frame, immediate ack, latency 7.
    push_frame(0, 3, 3);
    run_frame(0, 200, 0, 9);
    chk("inflight_peak_9x9", 64'(peak[0]), 64'd4);
    chk("wr_addr_after_frame", {48'd0, wr_addr[0]}, 64'd9);
    chk("err_clean_frame", {63'd0, err[0]}, 64'd0);

    // Stray valid while idle.
    @(posedge clk); #1 inj[0] = 1'b1;
    @(posedge clk); #1 inj[0] = 1'b0;
    chk("err_stray_valid", {63'd0, err[0]}, 64'd1);
    chk("wr_addr_stray_valid", {48'd0, wr_addr[0]}, 64'd9);

    // Start while busy must not restart the walk.
    push_frame(0, 3, 3);
    run_frame(0, 200, 5, 9);

    // Reset right after the 4th conv_en.
    for (int x = 0; x < 4; x++) exp_win[0].push_back({16'd0, 8'(x % 3), 8'(x / 3)});
    e0 = en_cnt[0];
    pulse_start(0);
    for (int c = 0; c < 100 && en_cnt[0] < e0 + 4; c++) @(posedge clk);
    chk("four_en_before_reset", 64'(en_cnt[0] - e0), 64'd4);
    #1 rst_n[0] = 1'b0;
    #1;
    chk("midframe_reset_outputs", {26'd0, win_req[0], conv_en[0], wr_en[0], busy[0], done[0], err[0],
                                   win_x[0], win_y[0], wr_addr[0]}, 64'd0);
    @(posedge clk); #1 rst_n[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("err_after_reset_pipeline", {63'd0, err[0]}, 64'd1);
    chk("wr_addr_after_reset", {48'd0, wr_addr[0]}, 64'd0);
    chk("busy_after_reset", {63'd0, busy[0]}, 64'd0);
    chk("win_queue_after_reset", 64'(exp_win[0].size()), 64'd0);
    push_frame(0, 3, 3);
    run_frame(0, 200, 0, 9);

    // MAX_INF = 2: back-pressure on win_req.
    push_frame(1, 3, 3);
    run_frame(1, 400, 0, 9);
    chk("inflight_peak_max2", 64'(peak[1]), 64'd2);
    chk("third_en_after_first_valid", 64'(en3_cyc[1] - first_wr_cyc[1]), 64'd2);
    chk("win_req_held", 64'(req_max[1] >= 3), 64'd1);
    chk("wr_addr_max2", {48'd0, wr_addr[1]}, 64'd9);

    // 28x28 frame: 484 windows.
    push_frame(2, 22, 22);
    run_frame(2, 3000, 0, 484);
    chk("wr_addr_28x28", {48'd0, wr_addr[2]}, 64'd484);
    chk("last_window_28x28", {48'd0, win_x[2], win_y[2]}, {48'd0, 8'd21, 8'd21});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
